mux4x2_sched: RTL and testbench
===============================

# mux4x2_sched

Round-robin scheduler that sequences the 4-to-2 lane mux in the PCIe physical-layer datapath. It watches four per-input FIFO "not empty" requests and two downstream lane-full flags. Each cycle it grants up to two distinct inputs onto output lanes 0 and 1. It drives the FIFO pops, the mux selects and the per-lane valids, all registered, and sequences start/drain through a small enable FSM.

## Interface
Parameters:
- CNT_W, 16, width of the wrapping grant counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start scheduling (1); request drain and stop (0).
- req  in  4  req[i]=1: input FIFO i holds at least one word.
- lane_full  in  2  lane_full[j]=1: output lane j cannot accept data this cycle.
- pop  out  4  registered pop strobe to input FIFO i; at most two bits set.
- sel0  out  2  registered mux select for lane 0 (index of granted input).
- sel1  out  2  registered mux select for lane 1.
- lane_valid  out  2  registered; lane_valid[j]=1 means selj carries a grant this cycle.
- state  out  2  FSM state: 0 IDLE, 1 ACTIVE, 2 DRAIN.
- grant_cnt  out  CNT_W  total words granted (pops), wraps modulo 2^CNT_W.

## Operation
- FSM transitions:
  - IDLE -> ACTIVE when enable=1.
  - ACTIVE -> DRAIN when enable=0.
  - DRAIN -> ACTIVE when enable=1.
  - DRAIN -> IDLE when enable=0 and eligible==0.
  - Encoding 3 is illegal and returns to IDLE.
- Grants are issued in ACTIVE and DRAIN only. In IDLE the next-cycle pop, lane_valid and select values are all 0.
- Eligibility: eligible = req & ~pop. An input popped in the current cycle is masked for one cycle, which covers the one-cycle FIFO empty-flag lag.
- Round-robin pointer ptr[1:0]: the search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Lane assignment:
  - Free lanes are those with lane_full[j]=0.
  - The lowest-numbered free lane takes the first eligible input in search order.
  - The other free lane, if any, takes the next eligible input after that one.
  - Both lanes never receive the same input.
- Pointer update: ptr <= (index of the last grant made this cycle) + 1 mod 4. ptr is unchanged when there is no grant.
- For a lane with no grant: lane_valid[j]=0 and selj=0.
- grant_cnt increments each cycle by popcount of the registered pop value (0, 1 or 2), wrapping.
- Reset values:
  - state=IDLE
  - ptr=0
  - pop=0
  - sel0=0
  - sel1=0
  - lane_valid=0
  - grant_cnt=0
- Reset has priority over every other input and clears any grant in flight. The output in the cycle after reset is all zeros.

## Timing
- Grant latency is 1 cycle. Inputs sampled at edge t produce pop/sel/lane_valid that are valid after edge t+1 and held for exactly one cycle.
- For each j, pop[selj] and lane_valid[j] assert in the same cycle. The datapath mux uses selj in that cycle.
- state updates on the edge after enable changes. The first grant can appear 2 cycles after enable rises from IDLE (state change, then grant register).
- A continuously requesting input is granted at most every other cycle because of the pop mask. Throughput with all four requesting and both lanes free is 2 grants per cycle.
- lane_full is sampled at decision time. A full lane receives no grant on the following cycle.
- With enable=0 in DRAIN, grants continue until the eligible set is empty. IDLE is entered on the same edge where eligible==0 is observed; no further grants follow.

## Test plan
- Reset: assert reset for 2 cycles with req=4'hF and enable=1 -> pop=0, lane_valid=0, state=0 and grant_cnt=0 during reset and for 1 cycle after reset.
- Full round robin:
  - Stimulus: enable=1, req=4'hF, lane_full=0.
  - Grant sequence (sel0,sel1): (0,1), (2,3), (0,1), …
  - Every grant cycle shows pop=4'h3 or 4'hC and lane_valid=2'b11.
  - grant_cnt increases by 2 per grant cycle.
- Lane stall: req=4'hF, lane_full=2'b01 -> only lane 1 valid; sel1 steps 0, 1, 2, 3; pop is one-hot.
- Single requester: req=4'b0100 held, both lanes free -> pop=4'b0100 every other cycle, sel0=2, lane_valid=2'b01 on grant cycles; lane 1 never valid.
- Drain:
  - Stimulus: while ACTIVE with req=4'h3, drop enable.
  - state=2 next cycle; grants continue.
  - Clear req -> state=0; no pop afterwards.
- Reset mid-burst: assert reset in the same cycle a two-lane grant is being decided -> the next cycle shows pop=0 and grant_cnt=0; ptr restarts at 0, so the first grant after re-enable is sel0=0.

Source files
------------

// File: rtl/mux4x2_sched_if.sv
// Handshake bundle between the lane scheduler and its surroundings:
// FIFO requests and lane back-pressure in; pops, selects, valids and status out.
interface mux4x2_sched_if #(
    parameter int unsigned CNT_W = 16
);
    logic             enable;
    logic [3:0]       req;
    logic [1:0]       lane_full;
    logic [3:0]       pop;
    logic [1:0]       sel0;
    logic [1:0]       sel1;
    logic [1:0]       lane_valid;
    logic [1:0]       state;
    logic [CNT_W-1:0] grant_cnt;

    modport master (
        output enable, req, lane_full,
        input  pop, sel0, sel1, lane_valid, state, grant_cnt
    );

    modport slave (
        input  enable, req, lane_full,
        output pop, sel0, sel1, lane_valid, state, grant_cnt
    );
endinterface

// File: rtl/mux4x2_sched.sv
// Round-robin scheduler for the 4-to-2 lane mux: grants up to two distinct
// inputs per cycle onto lanes 0/1, with an IDLE/ACTIVE/DRAIN enable FSM.
module mux4x2_sched #(
    parameter int unsigned CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    mux4x2_sched_if.slave  bus
);
    localparam int unsigned N_IN  = 4;
    localparam int unsigned SEL_W = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [N_IN-1:0]  r_pop;
    logic [N_IN-1:0]  w_pop_nxt;
    logic [SEL_W-1:0] r_sel0;
    logic [SEL_W-1:0] w_sel0_nxt;
    logic [SEL_W-1:0] r_sel1;
    logic [SEL_W-1:0] w_sel1_nxt;
    logic [1:0]       r_lane_valid;
    logic [1:0]       w_lane_valid_nxt;
    logic [CNT_W-1:0] r_grant_cnt;
    logic [N_IN-1:0]  w_eligible;
    logic             w_grant_en;
    logic             w_found1;
    logic             w_found2;
    logic [SEL_W-1:0] w_g1;
    logic [SEL_W-1:0] w_g2;
    logic [SEL_W-1:0] w_idx;

    // An input popped last cycle still looks non-empty for one cycle; mask it.
    assign w_eligible = bus.req & ~r_pop;
    assign w_grant_en = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.enable) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!bus.enable) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.enable) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_eligible == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // First and second eligible inputs in search order from the pointer,
    // then hand them to the free lanes, lowest-numbered lane first.
    always_comb begin
        w_found1         = 1'b0;
        w_found2         = 1'b0;
        w_g1             = '0;
        w_g2             = '0;
        w_idx            = '0;
        w_pop_nxt        = '0;
        w_sel0_nxt       = '0;
        w_sel1_nxt       = '0;
        w_lane_valid_nxt = '0;
        w_ptr_nxt        = r_ptr;

        for (int k = 0; k < int'(N_IN); k++) begin
            w_idx = r_ptr + SEL_W'(k);
            if (w_eligible[w_idx]) begin
                if (!w_found1) begin
                    w_found1 = 1'b1;
                    w_g1     = w_idx;
                end else if (!w_found2) begin
                    w_found2 = 1'b1;
                    w_g2     = w_idx;
                end
            end
        end

        if (w_grant_en && w_found1) begin
            if (!bus.lane_full[0]) begin
                w_lane_valid_nxt[0] = 1'b1;
                w_sel0_nxt          = w_g1;
                w_pop_nxt[w_g1]     = 1'b1;
                w_ptr_nxt           = w_g1 + SEL_W'(1);
                if (!bus.lane_full[1] && w_found2) begin
                    w_lane_valid_nxt[1] = 1'b1;
                    w_sel1_nxt          = w_g2;
                    w_pop_nxt[w_g2]     = 1'b1;
                    w_ptr_nxt           = w_g2 + SEL_W'(1);
                end
            end else if (!bus.lane_full[1]) begin
                w_lane_valid_nxt[1] = 1'b1;
                w_sel1_nxt          = w_g1;
                w_pop_nxt[w_g1]     = 1'b1;
                w_ptr_nxt           = w_g1 + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_pop        <= '0;
            r_sel0       <= '0;
            r_sel1       <= '0;
            r_lane_valid <= '0;
            r_grant_cnt  <= '0;
        end else begin
            r_ptr        <= w_ptr_nxt;
            r_pop        <= w_pop_nxt;
            r_sel0       <= w_sel0_nxt;
            r_sel1       <= w_sel1_nxt;
            r_lane_valid <= w_lane_valid_nxt;
            r_grant_cnt  <= r_grant_cnt + CNT_W'($countones(r_pop));
        end
    end

    assign bus.pop        = r_pop;
    assign bus.sel0       = r_sel0;
    assign bus.sel1       = r_sel1;
    assign bus.lane_valid = r_lane_valid;
    assign bus.state      = r_state;
    assign bus.grant_cnt  = r_grant_cnt;
endmodule

// File: tb/tb_mux4x2_sched.sv
// Scoreboard bench for mux4x2_sched: a driver predicts each cycle's outputs
// from a list-based reference model; a monitor compares after every clock edge.
module tb_mux4x2_sched;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [1:0]       state;
        logic [3:0]       pop;
        logic [1:0]       sel0;
        logic [1:0]       sel1;
        logic [1:0]       lv;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux4x2_sched_if #(.CNT_W(CNT_W)) bus ();

    mux4x2_sched #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               cyc      = 0;
    bit               mon_on   = 1'b0;

    int               m_state;
    int               m_ptr;
    logic [3:0]       m_pop;
    logic [CNT_W-1:0] m_cnt;

    // Expected outputs after the coming edge, from the scheduling rules.
    function automatic void model_push(input bit rst, input bit en,
                                       input logic [3:0] rq, input logic [1:0] lf);
        exp_t e;
        int   order[$];
        int   lanes[$];
        int   ns;
        bit   elig_any;
        e = '0;
        if (rst) begin
            m_state = 0;
            m_ptr   = 0;
            m_pop   = '0;
            m_cnt   = '0;
            exp_q.push_back(e);
            return;
        end
        e.cnt    = m_cnt + CNT_W'($countones(m_pop));
        elig_any = (rq & ~m_pop) != 4'h0;
        if (m_state == 1 || m_state == 2) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (rq[i] && !m_pop[i]) order.push_back(i);
            end
            for (int j = 0; j < 2; j++) if (!lf[j]) lanes.push_back(j);
            for (int n = 0; n < lanes.size() && n < order.size(); n++) begin
                e.lv[lanes[n]] = 1'b1;
                if (lanes[n] == 0) e.sel0 = 2'(order[n]);
                else               e.sel1 = 2'(order[n]);
                e.pop[order[n]] = 1'b1;
                m_ptr = (order[n] + 1) % 4;
            end
        end
        case (m_state)
            0:       ns = en ? 1 : 0;
            1:       ns = en ? 1 : 2;
            2:       ns = en ? 1 : (elig_any ? 2 : 0);
            default: ns = 0;
        endcase
        e.state = 2'(ns);
        m_state = ns;
        m_pop   = e.pop;
        m_cnt   = e.cnt;
        exp_q.push_back(e);
    endfunction

    task automatic step(input bit rst, input bit en, input logic [3:0] rq, input logic [1:0] lf);
        @(negedge clk);
        reset         = rst;
        bus.enable    = en;
        bus.req       = rq;
        bus.lane_full = lf;
        model_push(rst, en, rq, lf);
        mon_on = 1'b1;
    endtask

    // Monitor: every edge produces one registered output word to check.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                cyc++;
                n_checks++;
                act = {bus.state, bus.pop, bus.sel0, bus.sel1, bus.lane_valid, bus.grant_cnt};
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_underflow cyc=%0d no expected entry", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (act === e) begin
                        n_pass++;
                    end else begin
                        $display("FAIL outputs cyc=%0d got st=%0d pop=%h sel0=%0d sel1=%0d lv=%b cnt=%0d want st=%0d pop=%h sel0=%0d sel1=%0d lv=%b cnt=%0d",
                                 cyc, act.state, act.pop, act.sel0, act.sel1, act.lv, act.cnt,
                                 e.state, e.pop, e.sel0, e.sel1, e.lv, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        bit         en;
        logic [3:0] rq;
        reset         = 1'b1;
        bus.enable    = 1'b1;
        bus.req       = 4'hF;
        bus.lane_full = 2'b00;
        m_state = 0;
        m_ptr   = 0;
        m_pop   = '0;
        m_cnt   = '0;

        repeat (2) step(1'b1, 1'b1, 4'hF, 2'b00);
        // Full round robin, then lane 0 stalled, then a lone requester.
        repeat (10) step(1'b0, 1'b1, 4'hF, 2'b00);
        repeat (8)  step(1'b0, 1'b1, 4'hF, 2'b01);
        repeat (8)  step(1'b0, 1'b1, 4'b0100, 2'b00);
        // Drain with requests pending, then empty out to IDLE.
        repeat (4)  step(1'b0, 1'b1, 4'h3, 2'b00);
        repeat (3)  step(1'b0, 1'b0, 4'h3, 2'b00);
        repeat (4)  step(1'b0, 1'b0, 4'h0, 2'b00);
        // Reset in the middle of a two-lane burst.
        repeat (5)  step(1'b0, 1'b1, 4'hF, 2'b00);
        step(1'b1, 1'b1, 4'hF, 2'b00);
        repeat (5)  step(1'b0, 1'b1, 4'hF, 2'b00);

        en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            rq = 4'($urandom_range(0, 15));
            if (!en && $urandom_range(0, 1) == 0) rq = 4'h0;
            step(($urandom_range(0, 99) == 0), en, rq, 2'($urandom_range(0, 3)));
        end

        @(posedge clk);
        #2;
        mon_on = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL sb_leftover got %0d entries want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
